gbf_wr_sched: RTL and testbench

GBF_WR_SCHED -- requirements
Module: gbf_wr_sched

---
 rtl/ts3d_gbf_pkg.sv | 32 +++
 rtl/gbf_wr_hdr_dec.sv | 26 ++
 rtl/gbf_wr_sched.sv | 147 ++++++++++++++
 tb/tb_gbf_wr_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ts3d_gbf_pkg.sv
// Shared definitions for the global-buffer write scheduler: target ids,
// header field positions and the scheduler FSM state type.
package ts3d_gbf_pkg;

    localparam int NUM_TGT = 5;
    localparam int TGT_W   = 3;

    localparam logic [TGT_W-1:0] WEI    = 3'd0;
    localparam logic [TGT_W-1:0] FLGWEI = 3'd1;
    localparam logic [TGT_W-1:0] ACT    = 3'd2;
    localparam logic [TGT_W-1:0] FLGACT = 3'd3;
    localparam logic [TGT_W-1:0] VNACT  = 3'd4;

    // Target id sits in the top TGT_W bits of the header word.
    localparam int HDR_LEN_LSB  = 32;
    localparam int HDR_ADDR_LSB = 0;

    typedef enum logic {
        HDR   = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [TGT_W-1:0] tgt);
        logic [NUM_TGT-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (tgt == TGT_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/gbf_wr_hdr_dec.sv
// Combinational header decoder: splits a header word into target, length and
// base address, and flags headers that name no target or carry zero length.
module gbf_wr_hdr_dec
    import ts3d_gbf_pkg::*;
#(
    parameter int DAT_WIDTH  = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 13
) (
    input  logic [DAT_WIDTH-1:0]  hdr,
    output logic [TGT_W-1:0]      tgt,
    output logic [LEN_WIDTH-1:0]  len,
    output logic [ADDR_WIDTH-1:0] base,
    output logic                  valid
);

    // Only the three fields matter; the rest of the header word is reserved.
    logic unused_hdr;
    assign unused_hdr = ^hdr;

    assign tgt   = hdr[DAT_WIDTH-1 -: TGT_W];
    assign len   = hdr[HDR_LEN_LSB +: LEN_WIDTH];
    assign base  = hdr[HDR_ADDR_LSB +: ADDR_WIDTH];
    assign valid = (tgt <= VNACT) && (len != '0);

endmodule

// File: rtl/gbf_wr_sched.sv
// Global-buffer write scheduler: turns a header+payload stream into one-hot
// buffer writes. Define GBF_WR_SCHED_STALL_CNT_EN to add the Stall_Cnt output.
module gbf_wr_sched
    import ts3d_gbf_pkg::*;
#(
    parameter int DAT_WIDTH  = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IF_Val,
    output logic                  IF_Rdy,
    input  logic [DAT_WIDTH-1:0]  IF_Dat,
    input  logic [NUM_TGT-1:0]    GBF_Val,
    output logic [NUM_TGT-1:0]    GBF_EnWr,
    output logic [ADDR_WIDTH-1:0] GBF_AddrWr,
    output logic [DAT_WIDTH-1:0]  GBF_DatWr,
    output logic                  Done,
`ifdef GBF_WR_SCHED_STALL_CNT_EN
    output logic [31:0]           Stall_Cnt,
`endif
    output logic                  Err
);

    state_t                state, state_nxt;
    logic [TGT_W-1:0]      tgt_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [NUM_TGT-1:0]    en_q;
    logic [ADDR_WIDTH-1:0] addr_wr_q;
    logic [DAT_WIDTH-1:0]  dat_wr_q;
    logic                  done_q;
    logic                  err_q;

    logic [TGT_W-1:0]      dec_tgt;
    logic [LEN_WIDTH-1:0]  dec_len;
    logic [ADDR_WIDTH-1:0] dec_base;
    logic                  dec_valid;

    logic                  rdy;
    logic                  accept;
    logic                  tgt_ready;
    logic                  last_word;

    gbf_wr_hdr_dec #(
        .DAT_WIDTH  (DAT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_hdr_dec (
        .hdr   (IF_Dat),
        .tgt   (dec_tgt),
        .len   (dec_len),
        .base  (dec_base),
        .valid (dec_valid)
    );

    // Masking with the one-hot target makes the other GBF_Val bits irrelevant.
    assign tgt_ready = |(GBF_Val & tgt_onehot(tgt_q));
    assign last_word = (rem_q == LEN_WIDTH'(1));
    assign accept    = IF_Val && rdy;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        rdy       = 1'b0;
        state_nxt = state;
        if (!rst_n) begin
            unique case (state)
                HDR: begin
                    rdy = 1'b1;
                    if (IF_Val && dec_valid) state_nxt = BURST;
                end
                BURST: begin
                    rdy = tgt_ready;
                    if (IF_Val && tgt_ready && last_word) state_nxt = HDR;
                end
                default: state_nxt = HDR;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources, independent of block order.
    always_ff @(posedge clk) begin
        if (rst_n) state <= HDR;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tgt_q     <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
            en_q      <= '0;
            addr_wr_q <= '0;
            dat_wr_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            en_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                if (state == HDR) begin
                    if (dec_valid) begin
                        tgt_q  <= dec_tgt;
                        rem_q  <= dec_len;
                        addr_q <= dec_base;
                    end else begin
                        err_q  <= 1'b1;
                    end
                end else begin
                    en_q      <= tgt_onehot(tgt_q);
                    addr_wr_q <= addr_q;
                    dat_wr_q  <= IF_Dat;
                    addr_q    <= addr_q + ADDR_WIDTH'(1);
                    rem_q     <= rem_q - LEN_WIDTH'(1);
                    done_q    <= last_word;
                end
            end
        end
    end

`ifdef GBF_WR_SCHED_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_q <= '0;
        end else if (state == BURST && IF_Val && !tgt_ready && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign Stall_Cnt = stall_q;
`endif

    assign IF_Rdy     = rdy;
    assign GBF_EnWr   = en_q;
    assign GBF_AddrWr = addr_wr_q;
    assign GBF_DatWr  = dat_wr_q;
    assign Done       = done_q;
    assign Err        = err_q;

endmodule

// File: tb/tb_gbf_wr_sched.sv
// Directed self-checking bench for gbf_wr_sched; covers normal, back-pressure,
// wrap, invalid-header, back-to-back and mid-burst-reset scenarios.
module tb_gbf_wr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IF_Val;
    logic        IF_Rdy;
    logic [63:0] IF_Dat;
    logic [4:0]  GBF_Val;
    logic [4:0]  GBF_EnWr;
    logic [11:0] GBF_AddrWr;
    logic [63:0] GBF_DatWr;
    logic        Done;
    logic        Err;
`ifdef GBF_WR_SCHED_STALL_CNT_EN
    logic [31:0] Stall_Cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic rdy_seen;

    gbf_wr_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IF_Val     (IF_Val),
        .IF_Rdy     (IF_Rdy),
        .IF_Dat     (IF_Dat),
        .GBF_Val    (GBF_Val),
        .GBF_EnWr   (GBF_EnWr),
        .GBF_AddrWr (GBF_AddrWr),
        .GBF_DatWr  (GBF_DatWr),
        .Done       (Done),
`ifdef GBF_WR_SCHED_STALL_CNT_EN
        .Stall_Cnt  (Stall_Cnt),
`endif
        .Err        (Err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] hdr(input logic [2:0] t, input logic [12:0] len,
                                        input logic [11:0] base);
        logic [63:0] h;
        h = '0;
        h[63:61] = t;
        h[44:32] = len;
        h[11:0]  = base;
        return h;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, capture IF_Rdy before the edge, then step
    // to 1 time unit past the edge so registered outputs are stable.
    task automatic cycle(input logic rst, input logic v, input logic [63:0] d,
                         input logic [4:0] gv);
        rst_n   = rst;
        IF_Val  = v;
        IF_Dat  = d;
        GBF_Val = gv;
        #1;
        rdy_seen = IF_Rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_write(input string tag, input logic [4:0] en, input logic [11:0] a,
                             input logic [63:0] d, input logic dn);
        check({tag, ".en"},   64'(GBF_EnWr), 64'(en));
        check({tag, ".addr"}, 64'(GBF_AddrWr), 64'(a));
        check({tag, ".dat"},  GBF_DatWr, d);
        check({tag, ".done"}, 64'(Done), 64'(dn));
        check({tag, ".err"},  64'(Err), 64'd0);
    endtask

    task automatic exp_idle(input string tag, input logic er);
        check({tag, ".en"},   64'(GBF_EnWr), 64'd0);
        check({tag, ".done"}, 64'(Done), 64'd0);
        check({tag, ".err"},  64'(Err), 64'(er));
    endtask

    initial begin
        // Reset
        cycle(1'b1, 1'b1, 64'h0, 5'h1f);
        check("rst.rdy", 64'(rdy_seen), 64'd0);
        cycle(1'b1, 1'b0, 64'h0, 5'h1f);
        exp_write("rst", 5'b00000, 12'h000, 64'h0, 1'b0);
`ifdef GBF_WR_SCHED_STALL_CNT_EN
        check("rst.stall", 64'(Stall_Cnt), 64'd0);
`endif

        // Normal burst: tgt 2, len 4, base 0x010
        cycle(1'b0, 1'b1, hdr(3'd2, 13'd4, 12'h010), 5'h1f);
        check("n.hdr.rdy", 64'(rdy_seen), 64'd1);
        exp_idle("n.hdr", 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 64'hA000_0000_0000_0000 + 64'(i), 5'h1f);
            check($sformatf("n.w%0d.rdy", i), 64'(rdy_seen), 64'd1);
            exp_write($sformatf("n.w%0d", i), 5'b00100, 12'h010 + 12'(i),
                      64'hA000_0000_0000_0000 + 64'(i), i == 3);
        end
        cycle(1'b0, 1'b0, 64'h0, 5'h1f);
        exp_idle("n.after", 1'b0);

        // Back-pressure: only ACT ready bit toggled, others ignored
        cycle(1'b0, 1'b1, hdr(3'd2, 13'd4, 12'h010), 5'h1f);
        exp_idle("bp.hdr", 1'b0);
        cycle(1'b0, 1'b1, 64'hB0, 5'b00100);
        exp_write("bp.w0", 5'b00100, 12'h010, 64'hB0, 1'b0);
        cycle(1'b0, 1'b1, 64'hB1, 5'b00100);
        exp_write("bp.w1", 5'b00100, 12'h011, 64'hB1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 64'hB2, 5'b11011);
            check($sformatf("bp.s%0d.rdy", i), 64'(rdy_seen), 64'd0);
            exp_write($sformatf("bp.s%0d", i), 5'b00000, 12'h011, 64'hB1, 1'b0);
        end
`ifdef GBF_WR_SCHED_STALL_CNT_EN
        check("bp.stall", 64'(Stall_Cnt), 64'd3);
`endif
        cycle(1'b0, 1'b1, 64'hB2, 5'b00100);
        check("bp.w2.rdy", 64'(rdy_seen), 64'd1);
        exp_write("bp.w2", 5'b00100, 12'h012, 64'hB2, 1'b0);
        cycle(1'b0, 1'b1, 64'hB3, 5'b00100);
        exp_write("bp.w3", 5'b00100, 12'h013, 64'hB3, 1'b1);

        // Address wrap: tgt 0, len 3, base 0xFFE
        cycle(1'b0, 1'b1, hdr(3'd0, 13'd3, 12'hFFE), 5'h1f);
        exp_idle("wr.hdr", 1'b0);
        cycle(1'b0, 1'b1, 64'hC0, 5'h1f);
        exp_write("wr.w0", 5'b00001, 12'hFFE, 64'hC0, 1'b0);
        cycle(1'b0, 1'b1, 64'hC1, 5'h1f);
        exp_write("wr.w1", 5'b00001, 12'hFFF, 64'hC1, 1'b0);
        cycle(1'b0, 1'b1, 64'hC2, 5'h1f);
        exp_write("wr.w2", 5'b00001, 12'h000, 64'hC2, 1'b1);

        // Invalid headers, then back-to-back single-word bursts
        cycle(1'b0, 1'b1, hdr(3'd5, 13'd2, 12'h020), 5'h1f);
        check("inv1.rdy", 64'(rdy_seen), 64'd1);
        exp_idle("inv1", 1'b1);
        cycle(1'b0, 1'b1, hdr(3'd1, 13'd0, 12'h020), 5'h1f);
        check("inv2.rdy", 64'(rdy_seen), 64'd1);
        exp_idle("inv2", 1'b1);
        cycle(1'b0, 1'b1, hdr(3'd4, 13'd1, 12'h030), 5'h1f);
        check("b2b.h0.rdy", 64'(rdy_seen), 64'd1);
        exp_idle("b2b.h0", 1'b0);
        cycle(1'b0, 1'b1, 64'hD0, 5'h1f);
        exp_write("b2b.w0", 5'b10000, 12'h030, 64'hD0, 1'b1);
        cycle(1'b0, 1'b1, hdr(3'd3, 13'd1, 12'h040), 5'h1f);
        check("b2b.h1.rdy", 64'(rdy_seen), 64'd1);
        exp_idle("b2b.h1", 1'b0);
        cycle(1'b0, 1'b1, 64'hD1, 5'h1f);
        exp_write("b2b.w1", 5'b01000, 12'h040, 64'hD1, 1'b1);

        // Mid-burst reset: tgt 1, len 8, reset after word 3
        cycle(1'b0, 1'b1, hdr(3'd1, 13'd8, 12'h100), 5'h1f);
        exp_idle("mr.hdr", 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 64'hE0 + 64'(i), 5'h1f);
            exp_write($sformatf("mr.w%0d", i), 5'b00010, 12'h100 + 12'(i),
                      64'hE0 + 64'(i), 1'b0);
        end
        cycle(1'b1, 1'b1, 64'hE3, 5'h1f);
        check("mr.rst.rdy", 64'(rdy_seen), 64'd0);
        exp_write("mr.rst", 5'b00000, 12'h000, 64'h0, 1'b0);
`ifdef GBF_WR_SCHED_STALL_CNT_EN
        check("mr.stall", 64'(Stall_Cnt), 64'd0);
`endif
        cycle(1'b0, 1'b1, hdr(3'd2, 13'd1, 12'h050), 5'h1f);
        check("mr.h.rdy", 64'(rdy_seen), 64'd1);
        exp_idle("mr.h", 1'b0);
        cycle(1'b0, 1'b1, 64'hF0, 5'h1f);
        exp_write("mr.w", 5'b00100, 12'h050, 64'hF0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 5'h1f);
        exp_idle("mr.end", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
